// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// digit_serial_adder : WIDTH-bit add with carry-in, one DIGIT-bit slice per
//                      clock, LSB first; optional ovf via DIGIT_SERIAL_ADDER_OVF_EN
// Revision 1.0
// ============================================================================
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST       = CW'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             cy_q, cy_d, cout_q, cout_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [31:0]      lo;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] a_slice, b_slice;
  logic [DIGIT:0]   slice_sum;

  // Shifting the operands avoids variable-index part selects on the slice.
  assign lo        = 32'(cnt_q) * 32'(DIGIT);
  assign a_sh      = a_q >> lo;
  assign b_sh      = b_q >> lo;
  assign a_slice   = a_sh[DIGIT-1:0];
  assign b_slice   = b_sh[DIGIT-1:0];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = num1;
          b_d     = num2;
          cy_d    = c_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cy_d  = slice_sum[DIGIT];
        acc_d = (acc_q & ~(SLICE_MASK << lo)) | (WIDTH'(slice_sum[DIGIT-1:0]) << lo);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = slice_sum[DIGIT];
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_digit_serial_adder : directed bench over four WIDTH/DIGIT configurations
// Revision 1.0
// ============================================================================
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, DIGIT=4
  logic        s8 = 1'b0, ci8 = 1'b0, busy8, done8, co8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  // WIDTH=16, DIGIT=4
  logic        s16 = 1'b0, ci16 = 1'b0, busy16, done16, co16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  // WIDTH=8, DIGIT=1
  logic        s1 = 1'b0, ci1 = 1'b0, busy1, done1, co1;
  logic [7:0]  a1 = '0, b1 = '0, sum1;
  // WIDTH=8, DIGIT=8
  logic        sf = 1'b0, cif = 1'b0, busyf, donef, cof;
  logic [7:0]  af = '0, bf = '0, sumf;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16, ovf1, ovff;
`endif

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .num1(a8), .num2(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(s16), .num1(a16), .num2(b16), .c_in(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(co16)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .num1(a1), .num2(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dutf (
    .clk(clk), .rst(rst), .start(sf), .num1(af), .num2(bf), .c_in(cif),
    .busy(busyf), .done(donef), .sum(sumf), .c_out(cof)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovff)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if ({busy8, done8, co8, sum8} !== 11'h0) begin errors++; $display("FAIL reset_dut8 got %h exp 0", {busy8, done8, co8, sum8}); end
    checks++; if ({busy16, done16, co16, sum16} !== 19'h0) begin errors++; $display("FAIL reset_dut16 got %h exp 0", {busy16, done16, co16, sum16}); end
    checks++; if ({busy1, done1, co1, sum1} !== 11'h0) begin errors++; $display("FAIL reset_dut1 got %h exp 0", {busy1, done1, co1, sum1}); end
    checks++; if ({busyf, donef, cof, sumf} !== 11'h0) begin errors++; $display("FAIL reset_dutf got %h exp 0", {busyf, donef, cof, sumf}); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    checks++; if ({ovf8, ovf16, ovf1, ovff} !== 4'h0) begin errors++; $display("FAIL reset_ovf got %b exp 0", {ovf8, ovf16, ovf1, ovff}); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_wrap;
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; s8 = 1'b1;
    tick; s8 = 1'b0;
    checks++; if ({busy8, done8} !== 2'b10) begin errors++; $display("FAIL wrap_cycle1 busy/done got %b exp 10", {busy8, done8}); end
    tick;
    checks++; if ({busy8, done8} !== 2'b10) begin errors++; $display("FAIL wrap_cycle2 busy/done got %b exp 10", {busy8, done8}); end
    tick;
    checks++; if ({busy8, done8} !== 2'b01) begin errors++; $display("FAIL wrap_done busy/done got %b exp 01", {busy8, done8}); end
    checks++; if ({co8, sum8} !== 9'h100) begin errors++; $display("FAIL wrap_result got %h exp 100", {co8, sum8}); end
    tick;
    checks++; if ({done8, co8, sum8} !== 10'h100) begin errors++; $display("FAIL wrap_hold got %h exp 100", {done8, co8, sum8}); end
  endtask

  task automatic test_basic;
    a8 = 8'h3A; b8 = 8'h45; ci8 = 1'b1; s8 = 1'b1;
    tick; s8 = 1'b0;
    tick; tick;
    checks++; if ({done8, co8, sum8} !== 10'h280) begin errors++; $display("FAIL basic_3a45 got %h exp 280", {done8, co8, sum8}); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL basic_ovf1 got %b exp 1", ovf8); end
`endif
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; s8 = 1'b1;
    tick; s8 = 1'b0;
    tick; tick;
    checks++; if ({done8, co8, sum8} !== 10'h230) begin errors++; $display("FAIL basic_1020 got %h exp 230", {done8, co8, sum8}); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL basic_ovf0 got %b exp 0", ovf8); end
`endif
  endtask

  task automatic test_busy_ignore;
    int extra;
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; s8 = 1'b1;
    tick;
    a8 = 8'hFF; b8 = 8'hFF;
    tick; s8 = 1'b0;
    a8 = 8'h55; b8 = 8'h66;
    tick;
    checks++; if ({done8, co8, sum8} !== 10'h246) begin errors++; $display("FAIL busy_ignore_result got %h exp 246", {done8, co8, sum8}); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done8 || busy8) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignore_dropped got %0d active cycles exp 0", extra); end
  endtask

  task automatic test_async_reset;
    int extra;
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; s8 = 1'b1;
    tick; s8 = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++; if ({busy8, done8, co8, sum8} !== 11'h0) begin errors++; $display("FAIL async_reset got %h exp 0", {busy8, done8, co8, sum8}); end
    tick;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done8) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL async_reset_no_done got %0d pulses exp 0", extra); end
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; s8 = 1'b1;
    tick; s8 = 1'b0;
    tick; tick;
    checks++; if ({done8, co8, sum8} !== 10'h203) begin errors++; $display("FAIL async_reset_fresh got %h exp 203", {done8, co8, sum8}); end
  endtask

  task automatic test_back_to_back;
    a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; s8 = 1'b1;
    tick; s8 = 1'b0;
    tick; tick;
    checks++; if ({done8, co8, sum8} !== 10'h233) begin errors++; $display("FAIL b2b_first got %h exp 233", {done8, co8, sum8}); end
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; s8 = 1'b1;
    tick; s8 = 1'b0;
    checks++; if ({busy8, done8, sum8} !== 10'h233) begin errors++; $display("FAIL b2b_accept got %h exp 233", {busy8, done8, sum8}); end
    tick;
    checks++; if ({done8, sum8} !== 9'h033) begin errors++; $display("FAIL b2b_hold got %h exp 033", {done8, sum8}); end
    tick;
    checks++; if ({done8, co8, sum8} !== 10'h300) begin errors++; $display("FAIL b2b_second got %h exp 300", {done8, co8, sum8}); end
  endtask

  task automatic test_wide;
    int busy_cnt;
    a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; s16 = 1'b1;
    tick; s16 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy16 && !done16) busy_cnt++;
      tick;
    end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL wide_busy got %0d cycles exp 4", busy_cnt); end
    checks++; if ({busy16, done16, co16, sum16} !== 19'h30000) begin errors++; $display("FAIL wide_result got %h exp 30000", {busy16, done16, co16, sum16}); end
  endtask

  task automatic test_digit1;
    int busy_cnt;
    a1 = 8'h7F; b1 = 8'h01; ci1 = 1'b0; s1 = 1'b1;
    tick; s1 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy1 && !done1) busy_cnt++;
      tick;
    end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL digit1_busy got %0d cycles exp 8", busy_cnt); end
    checks++; if ({busy1, done1, co1, sum1} !== 11'h280) begin errors++; $display("FAIL digit1_result got %h exp 280", {busy1, done1, co1, sum1}); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL digit1_ovf got %b exp 1", ovf1); end
`endif
  endtask

  task automatic test_full_digit;
    af = 8'hF0; bf = 8'h0F; cif = 1'b1; sf = 1'b1;
    tick; sf = 1'b0;
    checks++; if ({busyf, donef} !== 2'b10) begin errors++; $display("FAIL full_digit_busy got %b exp 10", {busyf, donef}); end
    tick;
    checks++; if ({busyf, donef, cof, sumf} !== 11'h300) begin errors++; $display("FAIL full_digit_result got %h exp 300", {busyf, donef, cof, sumf}); end
    tick;
    checks++; if (donef !== 1'b0) begin errors++; $display("FAIL full_digit_pulse got %b exp 0", donef); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_basic;
    test_busy_ignore;
    test_async_reset;
    test_back_to_back;
    test_wide;
    test_digit1;
    test_full_digit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
